alu_cmd_sequencer: RTL and testbench

//  Command-driven controller for the shared 7-bit ALU. Owns the accumulator (ALU operand A),

---
 rtl/alu_cmd_sequencer_pkg.sv | 39 +++
 rtl/alu_cmd_sequencer_alu.sv | 53 +++++
 rtl/alu_cmd_sequencer.sv | 165 ++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared definitions for the ALU command sequencer: datapath sizes, ALU opcodes,
// command kinds, FSM states and the signed-overflow helpers used by the ALU.
package alu_cmd_sequencer_pkg;

  localparam int ALU_W     = 7;
  localparam int REP_CNT_W = 4;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_OR    = 3'b011;
  localparam logic [2:0] OP_XOR   = 3'b100;
  localparam logic [2:0] OP_SHL   = 3'b101;
  localparam logic [2:0] OP_SHR   = 3'b110;
  localparam logic [2:0] OP_PASSB = 3'b111;

  typedef enum logic [1:0] {
    KIND_CLEAR  = 2'b00,
    KIND_LOAD   = 2'b01,
    KIND_EXEC   = 2'b10,
    KIND_REPEAT = 2'b11
  } kind_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  // Two's-complement overflow: operands agree in sign but the result does not.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

  function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb != b_msb) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/alu_cmd_sequencer_alu.sv
// Purely combinational 7-bit ALU. Carry is the adder carry-out for ADD, the borrow
// for SUB and the bit shifted out for SHL/SHR; logic ops and PASSB clear both flags.
module alu_cmd_sequencer_alu
  import alu_cmd_sequencer_pkg::*;
#(
  parameter int WIDTH = ALU_W
) (
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry,
  output logic             o_ovf
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_diff;

  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};

  always_comb begin
    o_result = {WIDTH{1'b0}};
    o_carry  = 1'b0;
    o_ovf    = 1'b0;
    case (i_op)
      OP_ADD: begin
        o_result = w_sum[WIDTH-1:0];
        o_carry  = w_sum[WIDTH];
        o_ovf    = add_ovf(i_a[WIDTH-1], i_b[WIDTH-1], w_sum[WIDTH-1]);
      end
      OP_SUB: begin
        o_result = w_diff[WIDTH-1:0];
        o_carry  = w_diff[WIDTH];
        o_ovf    = sub_ovf(i_a[WIDTH-1], i_b[WIDTH-1], w_diff[WIDTH-1]);
      end
      OP_AND:   o_result = i_a & i_b;
      OP_OR:    o_result = i_a | i_b;
      OP_XOR:   o_result = i_a ^ i_b;
      OP_SHL: begin
        o_result = {i_a[WIDTH-2:0], 1'b0};
        o_carry  = i_a[WIDTH-1];
      end
      OP_SHR: begin
        o_result = {1'b0, i_a[WIDTH-1:1]};
        o_carry  = i_a[0];
      end
      OP_PASSB: o_result = i_b;
      default:  o_result = i_b;
    endcase
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer around the shared ALU: owns the accumulator, accepts CLEAR/LOAD/
// EXEC/REPEAT commands over valid/ready and returns result plus flags over valid/ready.
module alu_cmd_sequencer
  import alu_cmd_sequencer_pkg::*;
#(
  parameter int WIDTH = ALU_W,
  parameter int CNT_W = REP_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_ena,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [1:0]       i_cmd_kind,
  input  logic [2:0]       i_cmd_op,
  input  logic [WIDTH-1:0] i_cmd_operand,
  input  logic [CNT_W-1:0] i_cmd_count,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic [WIDTH-1:0] o_res_data,
  output logic             o_res_carry,
  output logic             o_res_ovf,
  output logic             o_res_zero,
  output logic             o_res_neg,
  output logic             o_busy
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           r_state;
  state_e           w_next_state;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_operand;
  logic [2:0]       r_op;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic             r_ovf;
  logic             r_armed;

  kind_e            w_kind;
  logic             w_accept;
  logic [WIDTH-1:0] w_alu_result;
  logic             w_alu_carry;
  logic             w_alu_ovf;

  assign w_kind   = kind_e'(i_cmd_kind);
  assign w_accept = o_cmd_ready & i_cmd_valid;

  alu_cmd_sequencer_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .i_op     (r_op),
    .i_a      (r_acc),
    .i_b      (r_operand),
    .o_result (w_alu_result),
    .o_carry  (w_alu_carry),
    .o_ovf    (w_alu_ovf)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (i_ena) begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if ((w_kind == KIND_CLEAR) || (w_kind == KIND_LOAD)) begin
              w_next_state = ST_RESP;
            end else begin
              w_next_state = ST_RUN;
            end
          end else begin
            w_next_state = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (r_cnt == CNT_ONE) begin
            w_next_state = ST_RESP;
          end else begin
            w_next_state = ST_RUN;
          end
        end
        ST_RESP: begin
          if (i_res_ready) begin
            w_next_state = ST_IDLE;
          end else begin
            w_next_state = ST_RESP;
          end
        end
        default: w_next_state = ST_IDLE;
      endcase
    end else begin
      w_next_state = r_state;
    end
  end

  // zero/neg only qualify a presented response, so they stay 0 outside RESP and in reset.
  always_comb begin
    o_cmd_ready = i_ena & r_armed & (r_state == ST_IDLE);
    o_res_valid = (r_state == ST_RESP);
    o_busy      = (r_state != ST_IDLE);
    o_res_zero  = (r_state == ST_RESP) & (r_acc == {WIDTH{1'b0}});
    o_res_neg   = (r_state == ST_RESP) & r_acc[WIDTH-1];
  end

  assign o_res_data  = r_acc;
  assign o_res_carry = r_carry;
  assign o_res_ovf   = r_ovf;

  // Command latch, accumulator, iteration counter and flag registers; all frozen by ena=0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc     <= {WIDTH{1'b0}};
      r_operand <= {WIDTH{1'b0}};
      r_op      <= OP_ADD;
      r_cnt     <= CNT_ZERO;
      r_carry   <= 1'b0;
      r_ovf     <= 1'b0;
      r_armed   <= 1'b0;
    end else if (i_ena) begin
      r_armed <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op      <= i_cmd_op;
            r_operand <= i_cmd_operand;
            case (w_kind)
              KIND_CLEAR: begin
                r_acc   <= {WIDTH{1'b0}};
                r_carry <= 1'b0;
                r_ovf   <= 1'b0;
              end
              KIND_LOAD: begin
                r_acc   <= i_cmd_operand;
                r_carry <= 1'b0;
                r_ovf   <= 1'b0;
              end
              KIND_EXEC:   r_cnt <= CNT_ONE;
              KIND_REPEAT: r_cnt <= (i_cmd_count == CNT_ZERO) ? CNT_ONE : i_cmd_count;
              default:     r_cnt <= CNT_ONE;
            endcase
          end
        end
        ST_RUN: begin
          r_acc   <= w_alu_result;
          r_carry <= w_alu_carry;
          r_ovf   <= w_alu_ovf;
          r_cnt   <= r_cnt - CNT_ONE;
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench: directed scenarios plus randomized commands, checked every cycle
// against a transaction-level model (result computed arithmetically, latency as a countdown).
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_kind;
  logic [2:0] cmd_op;
  logic [6:0] cmd_operand;
  logic [3:0] cmd_count;
  logic       res_valid;
  logic       res_ready;
  logic [6:0] res_data;
  logic       res_carry, res_ovf, res_zero, res_neg, busy;

  int  n_tests = 0;
  int  n_fail  = 0;
  bit  rnd_mode = 1'b0;
  bit  dir_ena  = 1'b1;
  bit  dir_rdy  = 1'b1;

  // model state
  bit  m_armed;
  bit  m_resp;
  int  m_wait;
  int  m_acc, m_carry, m_ovf;

  always #5 clk = ~clk;

  alu_cmd_sequencer dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_ena         (ena),
    .i_cmd_valid   (cmd_valid),
    .o_cmd_ready   (cmd_ready),
    .i_cmd_kind    (cmd_kind),
    .i_cmd_op      (cmd_op),
    .i_cmd_operand (cmd_operand),
    .i_cmd_count   (cmd_count),
    .o_res_valid   (res_valid),
    .i_res_ready   (res_ready),
    .o_res_data    (res_data),
    .o_res_carry   (res_carry),
    .o_res_ovf     (res_ovf),
    .o_res_zero    (res_zero),
    .o_res_neg     (res_neg),
    .o_busy        (busy)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  function automatic int sgn(input int x);
    return (x >= 64) ? x - 128 : x;
  endfunction

  task automatic alu_ref(input int op, input int a, input int b, output int r, output int c, output int v);
    int s;
    c = 0;
    v = 0;
    case (op)
      0: begin s = a + b; r = s % 128; c = (s >= 128) ? 1 : 0; s = sgn(a) + sgn(b); v = (s > 63 || s < -64) ? 1 : 0; end
      1: begin r = (a - b + 128) % 128; c = (a < b) ? 1 : 0; s = sgn(a) - sgn(b); v = (s > 63 || s < -64) ? 1 : 0; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: begin r = (a * 2) % 128; c = a / 64; end
      6: begin r = a / 2; c = a % 2; end
      default: r = b;
    endcase
  endtask

  task automatic model_accept();
    int n, r, c, v;
    if (cmd_kind == 2'd0) begin
      m_acc = 0; m_carry = 0; m_ovf = 0; m_resp = 1'b1;
    end else if (cmd_kind == 2'd1) begin
      m_acc = int'(cmd_operand); m_carry = 0; m_ovf = 0; m_resp = 1'b1;
    end else begin
      n = (cmd_kind == 2'd2 || cmd_count == 4'd0) ? 1 : int'(cmd_count);
      for (int k = 0; k < n; k++) begin
        alu_ref(int'(cmd_op), m_acc, int'(cmd_operand), r, c, v);
        m_acc = r; m_carry = c; m_ovf = v;
      end
      m_wait = n;
    end
  endtask

  // reference model: advances on each enabled clock edge
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_armed = 1'b0; m_resp = 1'b0; m_wait = 0; m_acc = 0; m_carry = 0; m_ovf = 0;
      end else if (ena) begin
        if (m_wait > 0) begin
          m_wait--;
          if (m_wait == 0) m_resp = 1'b1;
        end else if (m_resp) begin
          if (res_ready) m_resp = 1'b0;
        end else if (m_armed && cmd_valid) begin
          model_accept();
        end
        m_armed = 1'b1;
      end
    end
  end

  // per-cycle comparison against the model
  initial begin
    bit m_busy;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        m_busy = (m_wait > 0) || m_resp;
        chk("cmd_ready", int'(cmd_ready), int'(ena && m_armed && !m_busy));
        chk("res_valid", int'(res_valid), int'(m_resp));
        chk("busy", int'(busy), int'(m_busy));
        if (m_resp) begin
          chk("res_data", int'(res_data), m_acc);
          chk("res_carry", int'(res_carry), m_carry);
          chk("res_ovf", int'(res_ovf), m_ovf);
          chk("res_zero", int'(res_zero), int'(m_acc == 0));
          chk("res_neg", int'(res_neg), int'(m_acc >= 64));
        end
      end else begin
        chk("rst_outputs", int'({cmd_ready, res_valid, busy, res_data, res_carry, res_ovf, res_zero, res_neg}), 0);
      end
    end
  end

  // ena / res_ready driver: directed values or random
  initial begin
    ena = 1'b0;
    res_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rnd_mode) begin
        ena = ($urandom_range(0, 9) != 0);
        res_ready = ($urandom_range(0, 3) != 0);
      end else begin
        ena = dir_ena;
        res_ready = dir_rdy;
      end
    end
  end

  task automatic send(input logic [1:0] k, input logic [2:0] op, input logic [6:0] opd, input logic [3:0] cnt);
    int b;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_kind = k; cmd_op = op; cmd_operand = opd; cmd_count = cnt;
    #1;
    b = 0;
    while (!cmd_ready && b < 300) begin
      @(negedge clk);
      #1;
      b++;
    end
    if (!cmd_ready) bound_fail("accept");
    else @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_kind = 2'($urandom_range(0, 3));
    cmd_op = 3'($urandom_range(0, 7));
    cmd_operand = 7'($urandom_range(0, 127));
    cmd_count = 4'($urandom_range(0, 15));
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      #2;
      cyc++;
    end while (!res_valid && cyc < 300);
    if (!res_valid) bound_fail("res_valid");
  endtask

  task automatic wait_idle();
    int b = 0;
    while ((busy || res_valid) && b < 300) begin
      @(negedge clk);
      #2;
      b++;
    end
    if (busy) bound_fail("idle");
  endtask

  initial begin
    int cyc, bcnt, captured;
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_kind = 2'd0; cmd_op = 3'd0; cmd_operand = 7'd0; cmd_count = 4'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    send(2'd1, 3'd0, 7'd5, 4'd0);
    wait_valid(cyc);
    chk("lat_load", cyc, 1);
    wait_idle();
    send(2'd2, 3'd0, 7'd3, 4'd0);
    wait_valid(cyc);
    chk("lat_exec", cyc, 2);
    chk("add_data", int'(res_data), 8);
    chk("add_flags", int'({res_carry, res_ovf, res_zero}), 0);
    chk("model_add", m_acc, 8);
    wait_idle();

    send(2'd1, 3'd0, 7'd63, 4'd0);
    send(2'd2, 3'd0, 7'd1, 4'd0);
    wait_valid(cyc);
    chk("ovf_data", int'(res_data), 64);
    chk("ovf_flags", int'({res_carry, res_ovf, res_neg}), 3);
    chk("model_ovf", m_ovf, 1);
    wait_idle();

    send(2'd1, 3'd0, 7'd5, 4'd0);
    send(2'd2, 3'd1, 7'd5, 4'd0);
    wait_valid(cyc);
    chk("sub_data", int'(res_data), 0);
    chk("sub_zero_neg", int'({res_zero, res_neg}), 2);
    wait_idle();

    send(2'd1, 3'd0, 7'd120, 4'd0);
    send(2'd3, 3'd0, 7'd1, 4'd10);
    bcnt = 0;
    captured = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #2;
      if (busy) bcnt++;
      if (res_valid) captured = int'({res_carry, res_data});
      if (!busy) break;
    end
    chk("rep_busy_cycles", bcnt, 11);
    chk("rep_wrap", captured, 2);
    chk("model_wrap", m_acc, 2);

    send(2'd1, 3'd0, 7'd9, 4'd0);
    send(2'd3, 3'd0, 7'd2, 4'd0);
    wait_valid(cyc);
    chk("rep0_lat", cyc, 2);
    chk("rep0_data", int'(res_data), 11);
    wait_idle();

    send(2'd1, 3'd0, 7'd10, 4'd0);
    wait_idle();
    dir_rdy = 1'b0;
    send(2'd2, 3'd4, 7'd5, 4'd0);
    wait_valid(cyc);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #2;
      chk("hold_valid", int'(res_valid), 1);
      chk("hold_data", int'(res_data), 15);
      chk("hold_ready", int'(cmd_ready), 0);
    end
    dir_rdy = 1'b1;
    wait_idle();

    send(2'd0, 3'd0, 7'd0, 4'd0);
    send(2'd3, 3'd0, 7'd7, 4'd8);
    repeat (2) @(negedge clk);
    dir_ena = 1'b0;
    repeat (3) @(negedge clk);
    dir_ena = 1'b1;
    wait_valid(cyc);
    chk("ena_drop_data", int'(res_data), 56);
    chk("ena_drop_flags", int'({res_carry, res_ovf}), 0);
    wait_idle();

    send(2'd1, 3'd0, 7'd3, 4'd0);
    send(2'd3, 3'd5, 7'd0, 4'd15);
    repeat (4) @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst", int'({cmd_ready, res_valid, busy, res_data, res_carry, res_ovf, res_zero, res_neg}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    send(2'd1, 3'd0, 7'd7, 4'd0);
    wait_valid(cyc);
    chk("post_rst_load", int'(res_data), 7);
    wait_idle();

    rnd_mode = 1'b1;
    for (int i = 0; i < 150; i++) begin
      send(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
           7'($urandom_range(0, 127)), 4'($urandom_range(0, 15)));
    end
    rnd_mode = 1'b0;
    repeat (2) @(negedge clk);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
